// File: rtl/cond_flag_unit.sv
// Condition/flag unit: holds the Z,N,C,V flags produced by the ALU and gates
// the decoder's write and PC-select strobes on each instruction's condition.
module cond_flag_unit #(
  parameter int                FLAG_W      = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              pcs,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic              no_write,
  output logic              cond_ex,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic [FLAG_W-1:0] flags
);

  logic [FLAG_W-1:0] r_flags;
  logic w_z, w_n, w_c, w_v;
  logic w_pass;
  logic w_go;

  assign w_z = r_flags[3];
  assign w_n = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Evaluated on the stored flags only; alu_flags is never bypassed.
  always_comb begin
    w_pass = 1'b1;
    case (cond)
      4'd0:    w_pass = w_z;
      4'd1:    w_pass = ~w_z;
      4'd2:    w_pass = w_c;
      4'd3:    w_pass = ~w_c;
      4'd4:    w_pass = w_n;
      4'd5:    w_pass = ~w_n;
      4'd6:    w_pass = w_v;
      4'd7:    w_pass = ~w_v;
      4'd8:    w_pass = w_c & ~w_z;
      4'd9:    w_pass = ~w_c | w_z;
      4'd10:   w_pass = (w_n == w_v);
      4'd11:   w_pass = (w_n != w_v);
      4'd12:   w_pass = ~w_z & (w_n == w_v);
      4'd13:   w_pass = w_z | (w_n != w_v);
      default: w_pass = 1'b1;
    endcase
  end

  assign cond_ex   = w_pass & ~rst;
  assign w_go      = en & cond_ex;
  assign pc_src    = pcs & w_go;
  assign reg_write = reg_w & w_go & ~no_write;
  assign mem_write = mem_w & w_go;
  assign flags     = r_flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= RESET_FLAGS;
    end else if (w_go) begin
      if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
      if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: directed scenarios, full cond x flags sweep and
// random instruction streams against a behavioural flag/condition model.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] cond = '0;
  logic [3:0] alu_flags = '0;
  logic [1:0] flag_w = '0;
  logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
  logic       cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] flags;

  int         npass = 0;
  int         ntotal = 0;
  logic [3:0] mflags = 4'b0000;

  cond_flag_unit #(.FLAG_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst(rst), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
    .no_write(no_write), .cond_ex(cond_ex), .pc_src(pc_src),
    .reg_write(reg_write), .mem_write(mem_write), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Conditions come in complementary pairs: even code = predicate, odd = its negation.
  function automatic bit model_cond(input int c, input logic [3:0] f);
    bit z, n, cy, v, base;
    z = f[3]; n = f[2]; cy = f[1]; v = f[0];
    case (c / 2)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return (c % 2 == 1) ? !base : base;
  endfunction

  // One instruction: drive at negedge, check strobes mid-cycle, check flags after the edge.
  task automatic apply(input bit e, input int c, input logic [3:0] af, input logic [1:0] fw,
                       input bit p, input bit rw, input bit mw, input bit nw);
    bit ce;
    en = e; cond = 4'(c); alu_flags = af; flag_w = fw;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    #1;
    ce = model_cond(c, mflags);
    chk("cond_ex",   {7'd0, cond_ex},   {7'd0, ce});
    chk("pc_src",    {7'd0, pc_src},    {7'd0, p && ce && e});
    chk("reg_write", {7'd0, reg_write}, {7'd0, rw && ce && e && !nw});
    chk("mem_write", {7'd0, mem_write}, {7'd0, mw && ce && e});
    @(posedge clk);
    if (e && ce) begin
      if (fw[1]) begin mflags[3] = af[3]; mflags[2] = af[2]; end
      if (fw[0]) begin mflags[1] = af[1]; mflags[0] = af[0]; end
    end
    @(negedge clk);
    chk("flags", {4'd0, flags}, {4'd0, mflags});
  endtask

  initial begin
    // Reset state
    en = 1'b1; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; cond = 4'd14;
    #2;
    chk("rst_flags", {4'd0, flags}, 8'h00);
    chk("rst_pc_src", {7'd0, pc_src}, 8'h00);
    chk("rst_reg_write", {7'd0, reg_write}, 8'h00);
    chk("rst_mem_write", {7'd0, mem_write}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    mflags = 4'b0000;

    // Asynchronous reset mid-cycle with flags=1111
    apply(1, 14, 4'b1111, 2'b11, 0, 0, 0, 0);
    chk("pre_rst_flags", {4'd0, flags}, 8'h0f);
    en = 1'b1; cond = 4'd14; flag_w = 2'b11; alu_flags = 4'b1010;
    pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; no_write = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {4'd0, flags}, 8'h00);
    chk("async_rst_pc_src", {7'd0, pc_src}, 8'h00);
    chk("async_rst_reg_write", {7'd0, reg_write}, 8'h00);
    chk("async_rst_mem_write", {7'd0, mem_write}, 8'h00);
    @(negedge clk);
    chk("rst_hold_flags", {4'd0, flags}, 8'h00);
    rst = 1'b0;
    mflags = 4'b0000;

    // Compare then branch
    apply(1, 14, 4'b1000, 2'b11, 0, 1, 0, 1);
    chk("cmp_flags", {4'd0, flags}, 8'h08);
    en = 1'b1; cond = 4'd0; pcs = 1'b1; flag_w = 2'b00; reg_w = 1'b0; no_write = 1'b0;
    #1;
    chk("beq_cond_ex", {7'd0, cond_ex}, 8'h01);
    chk("beq_pc_src", {7'd0, pc_src}, 8'h01);
    cond = 4'd1;
    #1;
    chk("bne_pc_src", {7'd0, pc_src}, 8'h00);
    @(negedge clk);
    apply(1, 1, 4'b0000, 2'b00, 1, 0, 0, 0);

    // Partial updates
    apply(1, 14, 4'b0110, 2'b11, 0, 0, 0, 0);
    apply(1, 14, 4'b1001, 2'b10, 0, 0, 0, 0);
    chk("partial_zn", {4'd0, flags}, 8'h0a);
    apply(1, 14, 4'b0001, 2'b01, 0, 0, 0, 0);
    chk("partial_cv", {4'd0, flags}, 8'h09);

    // Failed condition blocks flag write and strobes
    apply(1, 14, 4'b0000, 2'b11, 0, 0, 0, 0);
    apply(1, 0, 4'b1111, 2'b11, 1, 1, 1, 0);
    chk("fail_flags", {4'd0, flags}, 8'h00);

    // Stall then resume
    apply(1, 14, 4'b1010, 2'b11, 0, 0, 0, 0);
    apply(0, 14, 4'b0101, 2'b11, 1, 1, 1, 0);
    chk("stall_flags", {4'd0, flags}, 8'h0a);
    apply(1, 14, 4'b0101, 2'b11, 1, 1, 1, 0);
    chk("resume_flags", {4'd0, flags}, 8'h05);

    // Full sweep of cond against every stored flag value
    for (int f = 0; f < 16; f++) begin
      apply(1, 14, 4'(f), 2'b11, 0, 0, 0, 0);
      en = 1'b0; flag_w = 2'b00;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        chk($sformatf("sweep_f%0d_c%0d", f, c), {7'd0, cond_ex}, {7'd0, model_cond(c, 4'(f))});
      end
      if (f == 5) begin  // Z=0 N=1 V=1
        cond = 4'd12; #1; chk("spot_gt", {7'd0, cond_ex}, 8'h01);
        cond = 4'd11; #1; chk("spot_lt", {7'd0, cond_ex}, 8'h00);
      end
      if (f == 4) begin  // N=1 V=0
        cond = 4'd10; #1; chk("spot_ge", {7'd0, cond_ex}, 8'h00);
        cond = 4'd13; #1; chk("spot_le", {7'd0, cond_ex}, 8'h01);
      end
      @(negedge clk);
    end

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), 4'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d/%0d so far", npass, ntotal);
    $fatal(1);
  end

endmodule
